// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I load/store unit: funct3 width/sign codes
// for loads and stores, the LSU state enum, and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package rv32i_pkg;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    // True when funct3 names a real RV32I access of the given direction.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        logic legal;
        if (is_store) begin
            legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end else begin
            legal = (funct3 == F3_LB)  || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                    (funct3 == F3_LBU) || (funct3 == F3_LHU);
        end
        return legal;
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store unit.
//   funct3     in  3   access width/sign code
//   addr_lo    in  2   low address bits selecting the byte lane
//   store_data in  32  raw store data (rs2)
//   load_word  in  32  aligned word returned by memory
//   wstrb      out 4   byte strobes for a store
//   wdata      out 32  store data replicated into every lane of its width
//   rdata      out 32  selected load lane, sign- or zero-extended
// -----------------------------------------------------------------------------
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Pick the addressed byte and halfword out of the returned word.  A
    // halfword at an odd address simply uses the half chosen by addr[1].
    always_comb begin
        case (addr_lo)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    // Replicating the data means whichever lane the strobe picks already
    // holds the right bytes, so no barrel shifter is needed.
    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        rdata = 32'd0;
        case (funct3)
            F3_LB:   rdata = {{24{load_byte[7]}}, load_byte};
            F3_LH:   rdata = {{16{load_half[15]}}, load_half};
            F3_LW:   rdata = load_word;
            F3_LBU:  rdata = {24'd0, load_byte};
            F3_LHU:  rdata = {16'd0, load_half};
            default: rdata = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// RV32I data-memory access unit: accepts one load/store from execute, issues a
// single word-aligned memory request, and returns a one-cycle response.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word accesses skip memory and respond with
//                resp_misaligned=1
//   undefined -> misaligned accesses are issued normally, resp_misaligned=0
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_is_store, req_funct3, req_addr, req_wdata, req_rd   request fields
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb          memory request
//   mem_ready, mem_rdata                                     memory completion
//   resp_valid, resp_rdata, resp_rd, resp_err, resp_misaligned   response
//   busy              high whenever the unit is not idle
// -----------------------------------------------------------------------------
module load_store_unit
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        resp_misaligned,
    output logic        busy
);

    lsu_state_t  state;
    logic        acc_store;
    logic [2:0]  acc_funct3;
    logic [1:0]  acc_addr_lo;
    logic [4:0]  acc_rd;

    logic [2:0]  align_funct3;
    logic [1:0]  align_addr_lo;
    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata;
    logic [31:0] align_rdata;

    // One aligner serves both directions: while idle it shapes the incoming
    // store, while waiting on memory it extracts the load from the captured
    // request fields.
    assign align_funct3  = (state == IDLE) ? req_funct3    : acc_funct3;
    assign align_addr_lo = (state == IDLE) ? req_addr[1:0] : acc_addr_lo;

    lsu_align u_align (
        .funct3     (align_funct3),
        .addr_lo    (align_addr_lo),
        .store_data (req_wdata),
        .load_word  (mem_rdata),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .rdata      (align_rdata)
    );

`ifndef LSU_MISALIGN_TRAP_EN
    assign resp_misaligned = 1'b0;
`endif

    // Control FSM with every output registered.  Memory-side outputs are
    // loaded at acceptance and held untouched until mem_ready; response
    // fields are loaded on entry to RESP and cleared on exit, so they read
    // zero whenever resp_valid is low.  Reset clears everything, which also
    // abandons an in-flight memory access without producing a response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_wstrb   <= 4'd0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_rd     <= 5'd0;
            resp_err    <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_misaligned <= 1'b0;
`endif
            acc_store   <= 1'b0;
            acc_funct3  <= 3'd0;
            acc_addr_lo <= 2'd0;
            acc_rd      <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        acc_store   <= req_is_store;
                        acc_funct3  <= req_funct3;
                        acc_addr_lo <= req_addr[1:0];
                        acc_rd      <= req_rd;
                        req_ready   <= 1'b0;
                        busy        <= 1'b1;
                        if (!funct3_legal(req_is_store, req_funct3)) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rd    <= req_is_store ? 5'd0 : req_rd;
                        end
`ifdef LSU_MISALIGN_TRAP_EN
                        else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_misaligned <= 1'b1;
                            resp_rd         <= req_is_store ? 5'd0 : req_rd;
                        end
`endif
                        else begin
                            state     <= MEM;
                            mem_req   <= 1'b1;
                            mem_we    <= req_is_store;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_is_store ? align_wdata : 32'd0;
                            mem_wstrb <= req_is_store ? align_wstrb : 4'd0;
                        end
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state      <= RESP;
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        mem_addr   <= 32'd0;
                        mem_wdata  <= 32'd0;
                        mem_wstrb  <= 4'd0;
                        resp_valid <= 1'b1;
                        resp_rdata <= acc_store ? 32'd0 : align_rdata;
                        resp_rd    <= acc_store ? 5'd0 : acc_rd;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    busy       <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'd0;
                    resp_rd    <= 5'd0;
                    resp_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                    resp_misaligned <= 1'b0;
`endif
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
